// File: rtl/s2p_frame_aligner.sv
// Serial-to-parallel deserialiser with sync-word frame alignment and a
// one-entry valid/ready output holding register.
module s2p_frame_aligner #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hBC,
   parameter int               FRAME_WORDS = 4,
   parameter int               MISS_LIMIT  = 2,
   parameter bit               LSB_FIRST   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] pdata,
   output logic             pvalid,
   input  logic             pready,
   output logic             locked,
   output logic             overflow,
   output logic             sync_err
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int WC_W  = (FRAME_WORDS > 0) ? $clog2(FRAME_WORDS + 1) : 1;
   localparam int MC_W  = (MISS_LIMIT > 0) ? $clog2(MISS_LIMIT + 1) : 1;

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_n;
   logic [WIDTH-1:0]   r_sr;
   logic [WIDTH-1:0]   w_word;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [BIT_W-1:0]   w_bit_cnt_n;
   logic [WC_W-1:0]    r_word_cnt;
   logic [WC_W-1:0]    w_word_cnt_n;
   logic [MC_W-1:0]    r_miss_cnt;
   logic [MC_W-1:0]    w_miss_cnt_n;
   logic [MC_W-1:0]    w_miss_inc;
   logic               w_data_done;
   logic               w_sync_miss;

   logic [WIDTH-1:0]   r_pdata;
   logic               r_pvalid;
   logic               r_locked;
   logic               r_overflow;
   logic               r_sync_err;

   // Assembled word: the value the shift register takes if this bit is sampled.
   always_comb begin
      w_word = r_sr;
      if (LSB_FIRST) begin
         w_word = {din, r_sr[WIDTH-1:1]};
      end else begin
         w_word = {r_sr[WIDTH-2:0], din};
      end
   end

   assign w_miss_inc = r_miss_cnt + MC_W'(1);

   // Alignment FSM: next state, counters and per-word events.
   always_comb begin
      w_state_n    = r_state;
      w_bit_cnt_n  = r_bit_cnt;
      w_word_cnt_n = r_word_cnt;
      w_miss_cnt_n = r_miss_cnt;
      w_data_done  = 1'b0;
      w_sync_miss  = 1'b0;
      if (din_en) begin
         case (r_state)
            ST_SEARCH: begin
               if (w_word == SYNC_WORD) begin
                  w_state_n    = ST_LOCKED;
                  w_bit_cnt_n  = '0;
                  w_word_cnt_n = '0;
                  w_miss_cnt_n = '0;
               end else begin
                  w_state_n = ST_SEARCH;
               end
            end
            ST_LOCKED: begin
               if (r_bit_cnt == BIT_W'(WIDTH - 1)) begin
                  w_bit_cnt_n = '0;
                  if (r_word_cnt < WC_W'(FRAME_WORDS)) begin
                     w_data_done  = 1'b1;
                     w_word_cnt_n = r_word_cnt + WC_W'(1);
                  end else begin
                     w_word_cnt_n = '0;
                     if (w_word == SYNC_WORD) begin
                        w_miss_cnt_n = '0;
                     end else begin
                        w_sync_miss = 1'b1;
                        // Too many consecutive misses: search again from the live bit stream.
                        if (w_miss_inc == MC_W'(MISS_LIMIT)) begin
                           w_state_n    = ST_SEARCH;
                           w_miss_cnt_n = '0;
                        end else begin
                           w_miss_cnt_n = w_miss_inc;
                        end
                     end
                  end
               end else begin
                  w_bit_cnt_n = r_bit_cnt + BIT_W'(1);
               end
            end
            default: begin
               w_state_n = ST_SEARCH;
            end
         endcase
      end else begin
         w_state_n = r_state;
      end
   end

   // State, shift register and alignment counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_SEARCH;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state    <= w_state_n;
         r_bit_cnt  <= w_bit_cnt_n;
         r_word_cnt <= w_word_cnt_n;
         r_miss_cnt <= w_miss_cnt_n;
         if (din_en) begin
            r_sr <= w_word;
         end else begin
            r_sr <= r_sr;
         end
      end
   end

   // Holding register, handshake and status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pdata    <= '0;
         r_pvalid   <= 1'b0;
         r_locked   <= 1'b0;
         r_overflow <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_locked   <= (w_state_n == ST_LOCKED);
         r_sync_err <= w_sync_miss;
         r_overflow <= w_data_done & r_pvalid & ~pready;
         if (w_data_done && (!r_pvalid || pready)) begin
            r_pdata  <= w_word;
            r_pvalid <= 1'b1;
         end else if (r_pvalid && pready) begin
            r_pvalid <= 1'b0;
         end else begin
            r_pvalid <= r_pvalid;
         end
      end
   end

   assign pdata    = r_pdata;
   assign pvalid   = r_pvalid;
   assign locked   = r_locked;
   assign overflow = r_overflow;
   assign sync_err = r_sync_err;

endmodule

// File: tb/tb_s2p_frame_aligner.sv
// Self-checking bench for s2p_frame_aligner: table-driven word sequences
// with a scoreboard for forwarded words, plus hand-written corner cases.
module tb_s2p_frame_aligner;

   logic       clk;
   logic       reset;
   logic       din;
   logic       din_en;
   logic       pready;
   logic [7:0] pdata;
   logic       pvalid;
   logic       locked;
   logic       overflow;
   logic       sync_err;
   logic [7:0] pdata_l;
   logic       pvalid_l;
   logic       locked_l;
   logic       overflow_l;
   logic       sync_err_l;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [7:0] word;
      logic       fwd;
      logic       exp_lock;
      logic       exp_serr;
   } vec_t;

   vec_t       tbl [16];
   logic [7:0] sb_q [$];

   s2p_frame_aligner #(.WIDTH(8), .SYNC_WORD(8'hBC), .FRAME_WORDS(4), .MISS_LIMIT(2), .LSB_FIRST(1'b0)) dut (
      .clk(clk), .reset(reset), .din(din), .din_en(din_en),
      .pdata(pdata), .pvalid(pvalid), .pready(pready),
      .locked(locked), .overflow(overflow), .sync_err(sync_err)
   );

   s2p_frame_aligner #(.WIDTH(8), .SYNC_WORD(8'hBC), .FRAME_WORDS(4), .MISS_LIMIT(2), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .reset(reset), .din(din), .din_en(din_en),
      .pdata(pdata_l), .pvalid(pvalid_l), .pready(pready),
      .locked(locked_l), .overflow(overflow_l), .sync_err(sync_err_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: consume a word at the scoreboard if the handshake fires.
   task automatic step();
      logic [7:0] exp_w;
      @(negedge clk);
      if (pvalid && pready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected actual=%0h required=none", pdata);
         end else begin
            exp_w = sb_q.pop_front();
            chk("sb_data", 32'(pdata), 32'(exp_w));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit gap);
      if (gap) begin
         din_en = 1'b0;
         din    = ~b;
         step();
      end
      din    = b;
      din_en = 1'b1;
      step();
   endtask

   task automatic send_word(input logic [7:0] w, input bit gap);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i], gap);
      end
   endtask

   task automatic set_vec(input int idx, input logic [7:0] w, input logic f, input logic l, input logic s);
      tbl[idx] = '{word: w, fwd: f, exp_lock: l, exp_serr: s};
   endtask

   task automatic apply_table(input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (tbl[i].fwd) sb_q.push_back(tbl[i].word);
         send_word(tbl[i].word, gap);
         chk("locked", 32'(locked), 32'(tbl[i].exp_lock));
         chk("sync_err", 32'(sync_err), 32'(tbl[i].exp_serr));
      end
      din_en = 1'b0;
   endtask

   task automatic drain_check();
      din_en = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      din    = 1'b0;
      din_en = 1'b0;
      step();
      step();
      step();
      chk("rst_pdata", 32'(pdata), 32'd0);
      chk("rst_pvalid", 32'(pvalid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_flags", 32'({overflow, sync_err}), 32'd0);
      sb_q.delete();
      reset = 1'b1;
      step();
   endtask

   initial begin
      logic [7:0] hist;
      logic       b;
      reset  = 1'b1;
      din    = 1'b0;
      din_en = 1'b0;
      pready = 1'b1;
      #2;

      // Random bits that never form 0xBC: nothing locks, nothing is output.
      do_reset();
      hist = 8'h00;
      for (int i = 0; i < 64; i++) begin
         b = 1'($urandom_range(0, 1));
         if ({hist[6:0], b} == 8'hBC) b = ~b;
         hist = {hist[6:0], b};
         send_bit(b, 1'b0);
         chk("t1_idle", 32'({locked, pvalid}), 32'd0);
      end
      drain_check();

      // Basic frame with continuous consumer.
      do_reset();
      set_vec(0, 8'hBC, 1'b0, 1'b1, 1'b0);
      set_vec(1, 8'h11, 1'b1, 1'b1, 1'b0);
      set_vec(2, 8'h22, 1'b1, 1'b1, 1'b0);
      set_vec(3, 8'h33, 1'b1, 1'b1, 1'b0);
      set_vec(4, 8'h44, 1'b1, 1'b1, 1'b0);
      set_vec(5, 8'hBC, 1'b0, 1'b1, 1'b0);
      set_vec(6, 8'h55, 1'b1, 1'b1, 1'b0);
      apply_table(7, 1'b0);
      drain_check();

      // Backpressure: second word dropped with a single overflow pulse.
      do_reset();
      pready = 1'b0;
      send_word(8'hBC, 1'b0);
      chk("t3_locked", 32'(locked), 32'd1);
      sb_q.push_back(8'h11);
      send_word(8'h11, 1'b0);
      chk("t3_pvalid", 32'(pvalid), 32'd1);
      chk("t3_pdata", 32'(pdata), 32'h11);
      chk("t3_ovf_pre", 32'(overflow), 32'd0);
      send_word(8'h22, 1'b0);
      chk("t3_ovf", 32'(overflow), 32'd1);
      chk("t3_hold", 32'(pdata), 32'h11);
      din_en = 1'b0;
      step();
      chk("t3_ovf_once", 32'(overflow), 32'd0);
      chk("t3_hold2", 32'({pvalid, pdata}), 32'h111);
      pready = 1'b1;
      step();
      chk("t3_consumed", 32'(pvalid), 32'd0);
      drain_check();

      // Two missed syncs drop lock; a fresh sync relocks.
      do_reset();
      set_vec(0,  8'hBC, 1'b0, 1'b1, 1'b0);
      set_vec(1,  8'h11, 1'b1, 1'b1, 1'b0);
      set_vec(2,  8'h22, 1'b1, 1'b1, 1'b0);
      set_vec(3,  8'h33, 1'b1, 1'b1, 1'b0);
      set_vec(4,  8'h44, 1'b1, 1'b1, 1'b0);
      set_vec(5,  8'h00, 1'b0, 1'b1, 1'b1);
      set_vec(6,  8'h55, 1'b1, 1'b1, 1'b0);
      set_vec(7,  8'h66, 1'b1, 1'b1, 1'b0);
      set_vec(8,  8'h77, 1'b1, 1'b1, 1'b0);
      set_vec(9,  8'h88, 1'b1, 1'b1, 1'b0);
      set_vec(10, 8'hA5, 1'b0, 1'b0, 1'b1);
      set_vec(11, 8'hBC, 1'b0, 1'b1, 1'b0);
      set_vec(12, 8'h99, 1'b1, 1'b1, 1'b0);
      apply_table(13, 1'b0);
      step();
      chk("t4_serr_pulse", 32'(sync_err), 32'd0);
      drain_check();

      // din_en toggling; a sync value in a data slot is forwarded.
      do_reset();
      set_vec(0, 8'hBC, 1'b0, 1'b1, 1'b0);
      set_vec(1, 8'h3C, 1'b1, 1'b1, 1'b0);
      set_vec(2, 8'hBC, 1'b1, 1'b1, 1'b0);
      apply_table(3, 1'b1);
      set_vec(0, 8'h4D, 1'b1, 1'b1, 1'b0);
      apply_table(1, 1'b0);
      drain_check();

      // LSB-first instance, then asynchronous reset mid-word.
      do_reset();
      pready = 1'b0;
      send_word(8'h3D, 1'b0);
      chk("t6_lock_l", 32'(locked_l), 32'd1);
      send_word(8'h80, 1'b0);
      chk("t6_pvalid_l", 32'(pvalid_l), 32'd1);
      chk("t6_pdata_l", 32'(pdata_l), 32'h01);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_l", 32'({pdata_l, pvalid_l, locked_l, overflow_l, sync_err_l}), 32'd0);
      chk("t6_async", 32'({pdata, pvalid, locked, overflow, sync_err}), 32'd0);
      din_en = 1'b0;
      step();
      reset = 1'b1;
      step();
      send_word(8'h80, 1'b0);
      chk("t6_no_relock", 32'({locked_l, pvalid_l}), 32'd0);
      pready = 1'b1;
      drain_check();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
